fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage that sits directly upstream of instructionmemory and drives its `ADDR_Prog`.
- It tracks which PC and validity belong to the instruction currently on the memory's registered `data_out`, so the IF/ID register downstream gets an aligned (instr, pc, valid) triple.
- It handles pipeline stalls (re-fetch in place), branch/jump redirects (squash the wrong-path fetch) and end-of-program halt.

Parameters:
- PC_WIDTH, 32, width of the full program counter (word address).
- ADDR_WIDTH, 10, width of `ADDR_Prog`; must match the instruction memory.
- START_ADDR, 32'h1730, PC loaded on reset (group base; maps to memory index 0).
- END_ADDR, 32'h1749, PC of the last program instruction (index 25); fetching it enters HALT.
- CNT_WIDTH, 16, width of the fetch counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold the fetch stage; re-present the current instruction.
- redirect_valid  in  1  branch/jump taken; load redirect_addr.
- redirect_addr  in  PC_WIDTH  redirect target PC.
- ADDR_Prog  out  ADDR_WIDTH  address to instructionmemory (combinational).
- pc_out  out  PC_WIDTH  next PC to fetch (registered).
- fetch_pc  out  PC_WIDTH  PC of the instruction on memory `data_out` this cycle.
- fetch_valid  out  1  memory `data_out` this cycle is a real, correct-path instruction.
- halted  out  1  FSM is in HALT.
- fetch_count  out  CNT_WIDTH  number of valid fetches issued since reset, saturating.

Behaviour:
- Reset (rst=1 at edge): pc_out=START_ADDR, fetch_pc=START_ADDR, fetch_valid=0, halted=0, fetch_count=0, FSM=RUN. Reset overrides every other input, including mid-stall, mid-redirect and in HALT.
- Memory latency is 1 cycle: the address driven in cycle t appears on `data_out` in t+1. fetch_pc and fetch_valid are registered at the same edge, so all three align in t+1.
- ADDR_Prog = stall ? fetch_pc[ADDR_WIDTH-1:0] : pc_out[ADDR_WIDTH-1:0]. The memory subtracts its own offset modulo 2^ADDR_WIDTH; no offset is applied here.
- FSM states RUN and HALT. Edge priority: rst > redirect_valid > stall > HALT hold > normal.
- RUN, redirect_valid=1 (stall ignored):
  - pc_out <= redirect_addr; fetch_valid <= 0 (the cycle-t fetch is wrong-path and squashed).
  - fetch_pc <= old pc_out; fetch_count unchanged.
  - Redirect to END_ADDR stays in RUN; the halt check applies on the next issue.
- RUN, stall=1:
  - pc_out, fetch_pc, fetch_valid and fetch_count hold.
  - Memory re-reads fetch_pc, so `data_out` is stable for the whole stall.
  - A stall of any length releases cleanly.
- RUN, normal:
  - fetch_pc <= pc_out; fetch_valid <= 1; fetch_count += 1, saturating at all-ones.
  - If pc_out == END_ADDR: pc_out holds and FSM -> HALT. Otherwise pc_out <= pc_out + 1, wrapping modulo 2^PC_WIDTH.
- HALT:
  - pc_out holds; fetch_valid <= 0; halted=1; stall ignored; fetch_pc holds.
  - redirect_valid=1 -> pc_out <= redirect_addr, FSM -> RUN, halted <= 0, fetch_valid <= 0.
- halted is a registered output and is 1 exactly while the FSM is in HALT.
- No combinational path from redirect inputs to ADDR_Prog. The only combinational input on that path is stall.

Test Plan:
- Reset, then run 4 cycles, paired with instructionmemory → ADDR_Prog sequence 0x330, 0x331, 0x332, 0x333. From the cycle after the first issue: fetch_valid=1, fetch_pc=0x1730 with data_out=0x21E01730, then 0x1731 with data_out=0x21E11731. fetch_count=4.
- After fetching 0x1732, hold stall for 3 cycles → data_out stays at index 2, fetch_pc stays 0x1732, fetch_count frozen. On release, the next valid fetch is 0x1733.
- redirect_valid=1 with redirect_addr=0x1738 while pc_out=0x1734 → next cycle fetch_valid=0. The following cycle fetch_pc=0x1738, data_out=index 8, fetch_count unchanged by the squashed fetch.
- Run from reset to END_ADDR → fetch_pc=0x1749 valid once, then halted=1, fetch_valid=0, pc_out stays 0x1749, fetch_count=26. Stall while in HALT has no effect. Redirect to 0x1730 resumes, with halted=0 after the edge.
- Assert stall and redirect_valid together (target 0x1740) → redirect wins: pc_out=0x1740 and fetch_valid=0 on the next cycle.
- Assert rst during a stall and during HALT → all outputs return to reset values on the next edge; ADDR_Prog=0x330.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC controller: drives the instruction memory address and tracks the
// (pc, valid) pair that lines up with the memory's registered data output.
//   state   | meaning
//   ST_RUN  | issuing sequential fetches, honouring stall and redirect
//   ST_HALT | last program word issued; waits for a redirect to resume
module fetch_pc_unit #(
  parameter int                   PC_WIDTH   = 32,
  parameter int                   ADDR_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0]  START_ADDR = 'h1730,
  parameter logic [PC_WIDTH-1:0]  END_ADDR   = 'h1749,
  parameter int                   CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_addr,
  output logic [ADDR_WIDTH-1:0] ADDR_Prog,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  fetch_valid,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= START_ADDR;
      fetch_pc_q    <= START_ADDR;
      fetch_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    count_d       = count_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          // The word issued this cycle is wrong-path; squash it but keep its pc.
          pc_d          = redirect_addr;
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b0;
        end else if (!stall) begin
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
          if (count_q != {CNT_WIDTH{1'b1}}) begin
            count_d = count_q + CNT_ONE;
          end
          if (pc_q == END_ADDR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      ST_HALT: begin
        fetch_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // During a stall the memory re-reads the word already being presented downstream.
  assign ADDR_Prog   = stall ? fetch_pc_q[ADDR_WIDTH-1:0] : pc_q[ADDR_WIDTH-1:0];
  assign pc_out      = pc_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small registered instruction-memory model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [9:0]  ADDR_Prog;
  logic [31:0] pc_out;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .ADDR_Prog      (ADDR_Prog),
    .pc_out         (pc_out),
    .fetch_pc       (fetch_pc),
    .fetch_valid    (fetch_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory model: index = addr - 0x330; word = {0x21, 0xE0+idx, 0x1730+idx}
  logic [9:0]  mem_idx;
  logic [31:0] data_out;
  assign mem_idx = ADDR_Prog - 10'h330;
  always_ff @(posedge clk) begin
    data_out <= {8'h21, 8'hE0 + mem_idx[7:0], 16'h1730 + {6'b0, mem_idx}};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    pc_out, 32'h1730);
    chk({tag, "_fpc"},   fetch_pc, 32'h1730);
    chk({tag, "_fv"},    {31'b0, fetch_valid}, 32'd0);
    chk({tag, "_halt"},  {31'b0, halted}, 32'd0);
    chk({tag, "_cnt"},   {16'b0, fetch_count}, 32'd0);
    chk({tag, "_addr"},  {22'b0, ADDR_Prog}, 32'h330);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    // Sequential run
    tick();
    chk("run1_fv",   {31'b0, fetch_valid}, 32'd1);
    chk("run1_fpc",  fetch_pc, 32'h1730);
    chk("run1_data", data_out, 32'h21E01730);
    chk("run1_addr", {22'b0, ADDR_Prog}, 32'h331);
    tick();
    chk("run2_fpc",  fetch_pc, 32'h1731);
    chk("run2_data", data_out, 32'h21E11731);
    chk("run2_addr", {22'b0, ADDR_Prog}, 32'h332);
    tick();
    chk("run3_fpc",  fetch_pc, 32'h1732);
    chk("run3_cnt",  {16'b0, fetch_count}, 32'd3);

    // Stall for three cycles while 0x1732 is on data_out
    stall = 1'b1;
    #1;
    chk("stall_addr", {22'b0, ADDR_Prog}, 32'h332);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_fpc",  fetch_pc, 32'h1732);
      chk("stall_data", data_out, 32'h21E21732);
      chk("stall_cnt",  {16'b0, fetch_count}, 32'd3);
      chk("stall_fv",   {31'b0, fetch_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("rel_fpc",  fetch_pc, 32'h1733);
    chk("rel_data", data_out, 32'h21E31733);
    chk("rel_cnt",  {16'b0, fetch_count}, 32'd4);
    chk("rel_pc",   pc_out, 32'h1734);

    // Redirect 0x1734 -> 0x1738
    redirect_valid = 1'b1; redirect_addr = 32'h1738;
    tick();
    redirect_valid = 1'b0;
    chk("redir_fv",  {31'b0, fetch_valid}, 32'd0);
    chk("redir_pc",  pc_out, 32'h1738);
    chk("redir_cnt", {16'b0, fetch_count}, 32'd4);
    chk("redir_addr", {22'b0, ADDR_Prog}, 32'h338);
    tick();
    chk("redir2_fv",   {31'b0, fetch_valid}, 32'd1);
    chk("redir2_fpc",  fetch_pc, 32'h1738);
    chk("redir2_data", data_out, 32'h21E81738);
    chk("redir2_cnt",  {16'b0, fetch_count}, 32'd5);

    // Stall and redirect together: redirect wins
    stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h1740;
    tick();
    redirect_valid = 1'b0;
    chk("sr_pc",  pc_out, 32'h1740);
    chk("sr_fv",  {31'b0, fetch_valid}, 32'd0);
    chk("sr_fpc", fetch_pc, 32'h1739);
    chk("sr_cnt", {16'b0, fetch_count}, 32'd5);

    // Reset during stall (stall still high)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_stall");
    stall = 1'b0;

    // Run to END_ADDR
    for (int i = 0; i < 26; i++) begin
      tick();
      chk("end_fpc", fetch_pc, 32'h1730 + i);
      chk("end_fv",  {31'b0, fetch_valid}, 32'd1);
    end
    chk("end_cnt",  {16'b0, fetch_count}, 32'd26);
    chk("end_data", data_out, 32'h21F91749);
    chk("end_halt", {31'b0, halted}, 32'd1);
    tick();
    chk("halt_fv",  {31'b0, fetch_valid}, 32'd0);
    chk("halt_pc",  pc_out, 32'h1749);
    chk("halt_fpc", fetch_pc, 32'h1749);
    chk("halt_cnt", {16'b0, fetch_count}, 32'd26);
    chk("halt_h",   {31'b0, halted}, 32'd1);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("hstall_pc",  pc_out, 32'h1749);
    chk("hstall_h",   {31'b0, halted}, 32'd1);
    chk("hstall_cnt", {16'b0, fetch_count}, 32'd26);

    // Resume from HALT
    redirect_valid = 1'b1; redirect_addr = 32'h1730;
    tick();
    redirect_valid = 1'b0;
    chk("resume_h",   {31'b0, halted}, 32'd0);
    chk("resume_pc",  pc_out, 32'h1730);
    chk("resume_fv",  {31'b0, fetch_valid}, 32'd0);
    chk("resume_fpc", fetch_pc, 32'h1749);
    tick();
    chk("resume2_fpc", fetch_pc, 32'h1730);
    chk("resume2_fv",  {31'b0, fetch_valid}, 32'd1);
    chk("resume2_cnt", {16'b0, fetch_count}, 32'd27);

    // Redirect straight to END_ADDR stays in RUN, halts on its issue
    redirect_valid = 1'b1; redirect_addr = 32'h1749;
    tick();
    redirect_valid = 1'b0;
    chk("re_end_h",  {31'b0, halted}, 32'd0);
    chk("re_end_pc", pc_out, 32'h1749);
    tick();
    chk("re_end2_h",   {31'b0, halted}, 32'd1);
    chk("re_end2_fpc", fetch_pc, 32'h1749);
    chk("re_end2_cnt", {16'b0, fetch_count}, 32'd28);

    // Reset while halted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
